// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid: one valid/ready pipeline stage that holds up to two entries.
// The skid entry lets IN_READY come straight from a flop, so there is no
// combinational path from OUT_READY. FLUSH drops every stored entry.
//
// Ports:
//   CLK        clock, rising edge
//   RESET      synchronous reset, active low
//   FLUSH      synchronous kill of stored entries
//   IN_VALID   upstream payload present
//   IN_READY   this stage accepts IN_DATA this cycle
//   IN_DATA    upstream payload
//   OUT_VALID  OUT_DATA holds a live entry
//   OUT_READY  downstream accepts the head entry
//   OUT_DATA   head-entry payload
//   COUNT      occupancy, 0..2
//   STALL_CNT  saturating count of cycles with OUT_VALID=1, OUT_READY=0
module pipe_stage_skid #(
   parameter int unsigned      WIDTH     = 32,
   parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}},
   parameter bit               SKID      = 1'b1,
   parameter int unsigned      CNT_W     = 16
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic             FLUSH,
   input  logic             IN_VALID,
   output logic             IN_READY,
   input  logic [WIDTH-1:0] IN_DATA,
   output logic             OUT_VALID,
   input  logic             OUT_READY,
   output logic [WIDTH-1:0] OUT_DATA,
   output logic [1:0]       COUNT,
   output logic [CNT_W-1:0] STALL_CNT
);

   // The encoding equals the occupancy, so COUNT comes straight from it.
   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] main_q, main_d;
   logic [WIDTH-1:0] skid_q, skid_d;
   logic [CNT_W-1:0] stall_q, stall_d;
   logic             valid_q;
   logic             rdy_q;
   logic             in_fire;
   logic             out_fire;

   // Without the skid entry, ready must look at the downstream
   // handshake in the same cycle.
   assign IN_READY  = SKID ? rdy_q : (OUT_READY | ~valid_q);
   assign OUT_VALID = valid_q;
   assign OUT_DATA  = main_q;
   assign COUNT     = state_q;
   assign STALL_CNT = stall_q;

   assign in_fire  = IN_VALID & IN_READY;
   assign out_fire = valid_q & OUT_READY;

   always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      stall_d = stall_q;

      // Saturates at all ones; FLUSH does not touch it.
      if (valid_q && !OUT_READY && (stall_q != '1)) begin
         stall_d = stall_q + CNT_W'(1);
      end

      if (FLUSH) begin
         state_d = EMPTY;
         main_d  = RESET_VAL;
      end else begin
         unique case (state_q)
            EMPTY: begin
               if (in_fire) begin
                  main_d  = IN_DATA;
                  state_d = ONE;
               end
            end
            ONE: begin
               unique case ({in_fire, out_fire})
                  2'b11: main_d = IN_DATA;
                  2'b01: state_d = EMPTY;
                  2'b10: begin
                     // Unreachable with SKID=0: ready needs OUT_READY.
                     if (SKID) begin
                        skid_d  = IN_DATA;
                        state_d = TWO;
                     end
                  end
                  default: ;
               endcase
            end
            TWO: begin
               if (out_fire) begin
                  main_d  = skid_q;
                  state_d = ONE;
               end
            end
            default: state_d = EMPTY;
         endcase
      end
   end

   // Flag outputs are loaded from the next state so they stay pure flops.
   always_ff @(posedge CLK) begin
      if (!RESET) begin
         state_q <= EMPTY;
         main_q  <= RESET_VAL;
         skid_q  <= RESET_VAL;
         stall_q <= '0;
         valid_q <= 1'b0;
         rdy_q   <= 1'b1;
      end else begin
         state_q <= state_d;
         main_q  <= main_d;
         skid_q  <= skid_d;
         stall_q <= stall_d;
         valid_q <= (state_d != EMPTY);
         rdy_q   <= (state_d != TWO);
      end
   end

endmodule

// File: doc/pipe_stage_skid.md
PIPE_STAGE_SKID -- requirements
Module: pipe_stage_skid

Interface
REQ-001 SHALL have parameter WIDTH, default 32, payload width in bits (legal range 1..256).
REQ-002 SHALL have parameter RESET_VAL, default {WIDTH{1'b0}}, the payload value loaded at reset and flush (the PC slice of an ID/EX instance uses 32'hFFFF_FFFC).
REQ-003 SHALL have parameter SKID, default 1: 1 = two-entry skid buffer with registered IN_READY; 0 = single entry with combinational IN_READY.
REQ-004 SHALL have parameter CNT_W, default 16, stall-counter width.
REQ-005 CLK  input  1  clock; all state updates on the rising edge.
REQ-006 RESET  input  1  synchronous, active-low reset.
REQ-007 FLUSH  input  1  synchronous kill of all stored entries (branch taken or exception).
REQ-008 IN_VALID  input  1  upstream stage presents IN_DATA.
REQ-009 IN_READY  output  1  this stage accepts IN_DATA this cycle.
REQ-010 IN_DATA  input  WIDTH  upstream payload (control and operand fields concatenated).
REQ-011 OUT_VALID  output  1  OUT_DATA holds a live entry.
REQ-012 OUT_READY  input  1  downstream accepts; driven low by a memory BUSY_WAIT stall.
REQ-013 OUT_DATA  output  WIDTH  head-entry payload.
REQ-014 COUNT  output  2  occupancy: 0, 1 or 2.
REQ-015 STALL_CNT  output  CNT_W  cycles with OUT_VALID=1 and OUT_READY=0.

Function
REQ-016 SHALL define in_fire = IN_VALID & IN_READY and out_fire = OUT_VALID & OUT_READY.
REQ-017 SHALL implement states EMPTY (COUNT=0), ONE (COUNT=1, main register live) and TWO (COUNT=2, main and skid registers live).
REQ-018 SHALL, in EMPTY, on in_fire load main<=IN_DATA and go to ONE; otherwise stay in EMPTY.
REQ-019 SHALL, in ONE:
- in_fire & out_fire: load main<=IN_DATA, stay in ONE.
- out_fire only: go to EMPTY.
- in_fire only: load skid<=IN_DATA, go to TWO.
- neither: hold.
REQ-020 SHALL, in TWO, on out_fire move main<=skid and go to ONE; otherwise hold.
REQ-021 SHALL drive OUT_DATA=main and OUT_VALID=(state!=EMPTY) directly from registers.
REQ-022 SHALL, with SKID=1, drive IN_READY=(state!=TWO) from registered state only, with no combinational path from OUT_READY.
REQ-023 SHALL, with SKID=0, drive IN_READY=OUT_READY | ~OUT_VALID and never enter TWO.
REQ-024 SHALL deliver payloads in arrival order with 1-cycle latency from in_fire to OUT_VALID when empty; no entry is duplicated or dropped.
REQ-025 SHALL hold main and skid unchanged while OUT_READY=0 and no write is permitted.
REQ-026 SHALL, on FLUSH=1, go to EMPTY and set main<=RESET_VAL; any in_fire in that cycle is discarded, and STALL_CNT is unaffected.
REQ-027 SHALL apply priority RESET > FLUSH > normal operation.
REQ-028 SHALL increment STALL_CNT each cycle with OUT_VALID & ~OUT_READY and saturate at all-ones (no wrap).
REQ-029 SHALL leave the skid register content don't-care when state!=TWO; it is never observable on OUT_DATA.

Reset
REQ-030 SHALL, on a clock edge with RESET=0, set state EMPTY, main=skid=RESET_VAL, STALL_CNT=0; this gives OUT_VALID=0, COUNT=0, IN_READY=1 and OUT_DATA=RESET_VAL.
REQ-031 SHALL have the first in_fire after RESET returns to 1 behave as from EMPTY.

Verification
REQ-032 Reset: RESET=0 for 2 cycles, WIDTH=32, RESET_VAL=32'hFFFF_FFFC -> OUT_DATA=FFFF_FFFC, OUT_VALID=0, IN_READY=1, COUNT=0.
REQ-033 Streaming: OUT_READY=1, inputs 0x10,0x14,0x18 on consecutive cycles -> same values on OUT_DATA one cycle later each, COUNT=1 throughout.
REQ-034 Stall fill: OUT_READY=0, inputs 0xA then 0xB -> COUNT=2 and IN_READY=0 (SKID=1); after 5 stall cycles STALL_CNT=5. With OUT_READY=1 -> 0xA then 0xB out, then COUNT=0.
REQ-035 Flush with simultaneous input: COUNT=2, FLUSH=1 with IN_VALID=1 and IN_DATA=0xC -> next cycle COUNT=0, OUT_DATA=RESET_VAL, and 0xC never appears.
REQ-036 Saturation: CNT_W=4, hold a stall for 20 cycles -> STALL_CNT=15.
REQ-037 SKID=0: OUT_READY=0 with one entry -> IN_READY=0 in the same cycle; OUT_READY=1 -> IN_READY=1 in the same cycle, and COUNT never exceeds 1.
